// File: rtl/uart_si_pkg.sv
// rtl/uart_si_pkg.sv - shared constants and types for the UART simple-interface feeder
//
// Purpose: register map, control/status bit positions, feeder state enum and
//          a helper that packs the control-register write word.
// Ports:   none (package)
package uart_si_pkg;

  // Simple-interface register map of the UART slave
  localparam logic [3:0] UART_CR    = 4'h0;
  localparam logic [3:0] UART_TX_RX = 4'h4;
  localparam logic [3:0] UART_DR    = 4'h8;

  // Control register write fields
  localparam int CR_TR_EN     = 0;
  localparam int CR_REC_EN    = 1;
  localparam int CR_TX_LVL_LO = 4;
  localparam int CR_RX_LVL_LO = 6;

  // Status bits returned on rd when reading the control/status address
  localparam int ST_TX_FULL = 2;
  localparam int ST_RX_FULL = 3;

  typedef enum logic [2:0] {
    CFG_DR,
    CFG_CR,
    IDLE,
    POLL,
    GAP,
    PUSH
  } feeder_state_e;

  function automatic logic [31:0] cr_word(input logic       tr_en,
                                          input logic       rec_en,
                                          input logic [1:0] tx_lvl,
                                          input logic [1:0] rx_lvl);
    logic [31:0] w;
    w = 32'h0;
    w[CR_TR_EN]                      = tr_en;
    w[CR_REC_EN]                     = rec_en;
    w[CR_TX_LVL_LO+1:CR_TX_LVL_LO]   = tx_lvl;
    w[CR_RX_LVL_LO+1:CR_RX_LVL_LO]   = rx_lvl;
    return w;
  endfunction

endpackage

// File: rtl/si_gap_timer.sv
// rtl/si_gap_timer.sv - down-counter that spaces status polls while the TX FIFO is full
//
// Purpose: after a load pulse, done stays low for GAP-1 further cycles so the
//          caller spends exactly GAP cycles in its wait state.
// Ports:   clk, rstn  - clock, asynchronous active-low reset
//          load       - restart the gap (pulse on the edge entering the wait)
//          done       - high on the last cycle of the gap
module si_gap_timer #(
  parameter int GAP = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  output logic done
);

  localparam int W  = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int LV = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [W-1:0] LOAD_VAL = LV[W-1:0];

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/uart_si_feeder.sv
// rtl/uart_si_feeder.sv - simple-interface master that configures the UART and feeds its TX FIFO
//
// Purpose: programs divider (0x8) and control (0x0) after reset or cfg_load,
//          then writes stream bytes to 0x4, polling tx_full so the FIFO never overflows.
// Ports:   clk, rstn                     - clock, asynchronous active-low reset
//          cfg_div/tr_en/rec_en/tx_lvl/rx_lvl, cfg_load - configuration values and rerun pulse
//          s_valid, s_data, s_ready      - byte stream in
//          busy, tx_cnt                  - status
//          addr, re, we, wd, rd          - simple-interface bus to the UART slave
module uart_si_feeder
  import uart_si_pkg::*;
#(
  parameter int POLL_GAP = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [15:0]      cfg_div,
  input  logic             cfg_tr_en,
  input  logic             cfg_rec_en,
  input  logic [1:0]       cfg_tx_lvl,
  input  logic [1:0]       cfg_rx_lvl,
  input  logic             cfg_load,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic             busy,
  output logic [CNT_W-1:0] tx_cnt,
  output logic [3:0]       addr,
  output logic             re,
  output logic             we,
  output logic [31:0]      wd,
  input  logic [31:0]      rd
);

  feeder_state_e state, nxt;
  logic          pend;
  logic          gap_load, gap_done;
  logic          tx_full;
  logic [3:0]    nxt_addr;
  logic          nxt_re, nxt_we;
  logic [31:0]   nxt_wd;
  logic          unused_rd;

  assign tx_full   = rd[ST_TX_FULL];
  assign unused_rd = ^{rd[31:ST_TX_FULL+1], rd[ST_TX_FULL-1:0]};

  si_gap_timer #(.GAP(POLL_GAP)) u_gap (
    .clk  (clk),
    .rstn (rstn),
    .load (gap_load),
    .done (gap_done)
  );

  // Next-state and handshake
  always_comb begin
    nxt     = state;
    s_ready = 1'b0;
    case (state)
      // Reset leaves we low in CFG_DR; the first edge issues the divider write
      // and only a cycle that actually carried it moves on.
      CFG_DR: nxt = we ? CFG_CR : CFG_DR;
      CFG_CR: nxt = IDLE;
      IDLE: begin
        if (pend || cfg_load) nxt = CFG_DR;
        else if (s_valid)     nxt = POLL;
      end
      POLL: begin
        if (!tx_full) begin
          if (s_valid) begin
            s_ready = 1'b1;
            nxt     = PUSH;
          end else begin
            nxt = IDLE;
          end
        end else begin
          nxt = (POLL_GAP == 0) ? POLL : GAP;
        end
      end
      GAP:     if (gap_done) nxt = POLL;
      PUSH:    nxt = IDLE;
      default: nxt = CFG_DR;
    endcase
  end

  assign gap_load = (nxt == GAP) && (state != GAP);

  // Bus values for the state about to be entered; registered below so they
  // are stable for the whole state.
  always_comb begin
    nxt_addr = UART_CR;
    nxt_re   = 1'b0;
    nxt_we   = 1'b0;
    nxt_wd   = 32'h0;
    case (nxt)
      CFG_DR: begin
        nxt_addr = UART_DR;
        nxt_we   = 1'b1;
        nxt_wd   = {16'h0, cfg_div};
      end
      CFG_CR: begin
        nxt_addr = UART_CR;
        nxt_we   = 1'b1;
        nxt_wd   = cr_word(cfg_tr_en, cfg_rec_en, cfg_tx_lvl, cfg_rx_lvl);
      end
      POLL: begin
        nxt_addr = UART_CR;
        nxt_re   = 1'b1;
      end
      PUSH: begin
        // wd doubles as the latch for the accepted byte
        nxt_addr = UART_TX_RX;
        nxt_we   = 1'b1;
        nxt_wd   = {24'h0, s_data};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= CFG_DR;
      addr   <= 4'h0;
      re     <= 1'b0;
      we     <= 1'b0;
      wd     <= 32'h0;
      pend   <= 1'b0;
      tx_cnt <= '0;
    end else begin
      state <= nxt;
      addr  <= nxt_addr;
      re    <= nxt_re;
      we    <= nxt_we;
      wd    <= nxt_wd;
      if (state == IDLE && nxt == CFG_DR) pend <= 1'b0;
      else if (cfg_load && state != IDLE) pend <= 1'b1;
      if (state == PUSH) tx_cnt <= tx_cnt + CNT_W'(1);
    end
  end

  assign busy = (state == CFG_DR) || (state == CFG_CR) || (state == PUSH) ||
                (((state == POLL) || (state == GAP)) && s_valid);

endmodule

// File: tb/tb_uart_si_feeder.sv
// tb/tb_uart_si_feeder.sv - directed self-checking bench for uart_si_feeder
module tb_uart_si_feeder;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] cfg_div;
  logic        cfg_tr_en, cfg_rec_en, cfg_load;
  logic [1:0]  cfg_tx_lvl, cfg_rx_lvl;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        tx_full;

  logic        s_ready_a, busy_a, re_a, we_a;
  logic [15:0] tx_cnt_a;
  logic [3:0]  addr_a;
  logic [31:0] wd_a, rd_a;

  logic        s_ready_b, busy_b, re_b, we_b;
  logic [1:0]  tx_cnt_b;
  logic [3:0]  addr_b;
  logic [31:0] wd_b, rd_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign rd_a = (addr_a == 4'h0) ? {29'h0, tx_full, 2'b00} : 32'h0;
  assign rd_b = (addr_b == 4'h0) ? {29'h0, tx_full, 2'b00} : 32'h0;

  uart_si_feeder #(.POLL_GAP(4), .CNT_W(16)) u_dut (
    .clk(clk), .rstn(rstn), .cfg_div(cfg_div), .cfg_tr_en(cfg_tr_en),
    .cfg_rec_en(cfg_rec_en), .cfg_tx_lvl(cfg_tx_lvl), .cfg_rx_lvl(cfg_rx_lvl),
    .cfg_load(cfg_load), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_a),
    .busy(busy_a), .tx_cnt(tx_cnt_a), .addr(addr_a), .re(re_a), .we(we_a),
    .wd(wd_a), .rd(rd_a)
  );

  // Narrow counter and back-to-back polling variant, fed the same stimulus
  uart_si_feeder #(.POLL_GAP(0), .CNT_W(2)) u_dut_b (
    .clk(clk), .rstn(rstn), .cfg_div(cfg_div), .cfg_tr_en(cfg_tr_en),
    .cfg_rec_en(cfg_rec_en), .cfg_tx_lvl(cfg_tx_lvl), .cfg_rx_lvl(cfg_rx_lvl),
    .cfg_load(cfg_load), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_b),
    .busy(busy_b), .tx_cnt(tx_cnt_b), .addr(addr_b), .re(re_b), .we(we_b),
    .wd(wd_b), .rd(rd_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("re_we_excl_a", {31'h0, re_a & we_a}, 32'h0);
    check("re_we_excl_b", {31'h0, re_b & we_b}, 32'h0);
  endtask

  initial begin
    rstn = 1'b0; cfg_load = 1'b0; s_valid = 1'b0; s_data = 8'h00; tx_full = 1'b0;
    cfg_div = 16'd54; cfg_tr_en = 1'b1; cfg_rec_en = 1'b0;
    cfg_tx_lvl = 2'b11; cfg_rx_lvl = 2'b00;

    // Reset state
    tick(); tick();
    check("rst_addr",    {28'h0, addr_a}, 32'h0);
    check("rst_we",      {31'h0, we_a}, 32'h0);
    check("rst_re",      {31'h0, re_a}, 32'h0);
    check("rst_wd",      wd_a, 32'h0);
    check("rst_s_ready", {31'h0, s_ready_a}, 32'h0);
    check("rst_busy",    {31'h0, busy_a}, 32'h1);
    check("rst_tx_cnt",  {16'h0, tx_cnt_a}, 32'h0);
    rstn = 1'b1;

    // Configuration after reset
    tick();
    check("cfg_dr_we",   {31'h0, we_a}, 32'h1);
    check("cfg_dr_addr", {28'h0, addr_a}, 32'h8);
    check("cfg_dr_wd",   wd_a, 32'h36);
    tick();
    check("cfg_cr_we",   {31'h0, we_a}, 32'h1);
    check("cfg_cr_addr", {28'h0, addr_a}, 32'h0);
    check("cfg_cr_wd",   wd_a, 32'h31);
    tick();
    check("idle_we",     {31'h0, we_a}, 32'h0);
    check("idle_busy",   {31'h0, busy_a}, 32'h0);

    // Two back-to-back bytes, FIFO not full
    s_valid = 1'b1; s_data = 8'hA5;
    tick();
    check("b0_poll_re",  {31'h0, re_a}, 32'h1);
    check("b0_s_ready",  {31'h0, s_ready_a}, 32'h1);
    tick();
    check("b0_push_we",  {31'h0, we_a}, 32'h1);
    check("b0_push_adr", {28'h0, addr_a}, 32'h4);
    check("b0_push_wd",  wd_a, 32'hA5);
    s_data = 8'h3C;
    tick();
    check("b0_idle_we",  {31'h0, we_a}, 32'h0);
    check("b0_tx_cnt",   {16'h0, tx_cnt_a}, 32'h1);
    tick();
    check("b1_s_ready",  {31'h0, s_ready_a}, 32'h1);
    tick();
    check("b1_push_we",  {31'h0, we_a}, 32'h1);
    check("b1_push_wd",  wd_a, 32'h3C);
    s_valid = 1'b0;
    tick();
    check("b1_tx_cnt",   {16'h0, tx_cnt_a}, 32'h2);

    // FIFO full for ten cycles: polls every 5 cycles, never writes
    tx_full = 1'b1; s_valid = 1'b1; s_data = 8'h5A;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("full_re_c%0d", i), {31'h0, re_a}, {31'h0, (i == 1 || i == 6)});
      check($sformatf("full_we_c%0d", i), {31'h0, we_a}, 32'h0);
      check($sformatf("full_rdy_c%0d", i), {31'h0, s_ready_a}, 32'h0);
      check($sformatf("full_busy_c%0d", i), {31'h0, busy_a}, 32'h1);
      check($sformatf("full_re_b_c%0d", i), {31'h0, re_b}, 32'h1);
    end
    tx_full = 1'b0;
    tick();
    check("full_end_re", {31'h0, re_a}, 32'h1);
    check("full_end_rdy", {31'h0, s_ready_a}, 32'h1);
    tick();
    check("full_push_wd", wd_a, 32'h5A);
    check("full_push_we", {31'h0, we_a}, 32'h1);
    s_valid = 1'b0;
    tick();
    check("full_tx_cnt",   {16'h0, tx_cnt_a}, 32'h3);
    check("full_tx_cnt_b", {30'h0, tx_cnt_b}, 32'h3);

    // cfg_load during PUSH: byte completes, then reconfigure with new values
    cfg_div = 16'h0100; cfg_rec_en = 1'b1; cfg_rx_lvl = 2'b01;
    s_valid = 1'b1; s_data = 8'hC3;
    tick();
    tick();
    check("ld_push_wd", wd_a, 32'hC3);
    cfg_load = 1'b1; s_valid = 1'b0;
    tick();
    cfg_load = 1'b0;
    check("ld_idle_we",  {31'h0, we_a}, 32'h0);
    check("ld_tx_cnt",   {16'h0, tx_cnt_a}, 32'h4);
    check("wrap_tx_cnt_b", {30'h0, tx_cnt_b}, 32'h0);
    tick();
    check("ld_dr_addr", {28'h0, addr_a}, 32'h8);
    check("ld_dr_wd",   wd_a, 32'h100);
    check("ld_dr_we",   {31'h0, we_a}, 32'h1);
    tick();
    check("ld_cr_addr", {28'h0, addr_a}, 32'h0);
    check("ld_cr_wd",   wd_a, 32'h73);
    tick();
    check("ld_idle_busy", {31'h0, busy_a}, 32'h0);

    // Reset asserted during PUSH
    s_valid = 1'b1; s_data = 8'hE7;
    tick();
    tick();
    check("rp_push_we", {31'h0, we_a}, 32'h1);
    check("rp_push_wd", wd_a, 32'hE7);
    #2 rstn = 1'b0;
    #1;
    check("rp_async_we",  {31'h0, we_a}, 32'h0);
    check("rp_tx_cnt",    {16'h0, tx_cnt_a}, 32'h0);
    check("rp_busy",      {31'h0, busy_a}, 32'h1);
    s_valid = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    check("rp_dr_addr", {28'h0, addr_a}, 32'h8);
    check("rp_dr_wd",   wd_a, 32'h100);
    tick();
    check("rp_cr_wd",   wd_a, 32'h73);
    tick();
    check("rp_idle_we",  {31'h0, we_a}, 32'h0);
    check("rp_idle_adr", {28'h0, addr_a}, 32'h0);
    check("rp_cnt_end",  {16'h0, tx_cnt_a}, 32'h0);
    check("rp_cnt_end_b", {30'h0, tx_cnt_b}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
